// File: rtl/ip_packet_rx.sv
// ip_packet_rx -- receive side of the accelerator's Ethernet II / IPv4 link.
//
// Parses a byte-serial frame from the MAC RX stream, validates the Ethernet
// and IPv4 header fields that identify traffic for this accelerator, and
// extracts the sender MAC, sender IP and the 10-bit message. An accepted
// message is held until MESSAGE_ACK; the MAC is back-pressured meanwhile.
// Rejected frames bump a saturating DROP_COUNT.
//
// Ports:
//   ACLK, ARESET                     clock (rising), async active-high reset
//   ACCELERATOR_IP/MAC_ADDRESS       own addresses, first-on-wire byte in the MSBs
//   MAC_DATA_IN/VALID/READY/LAST     RX byte stream with handshake
//   MAC_DATA_TUSER                   MAC frame error, qualified by LAST
//   SENDER_MAC/IP_ADDRESS, SENDER_MESSAGE, MESSAGE_VALID, MESSAGE_ACK
//                                    extracted result and its handshake
//   DROP_COUNT                       rejected frames, saturating
//
// Build option: define IP_RX_CHECKSUM_EN to verify the IPv4 header checksum
// (bytes 14-33); otherwise the checksum bytes are ignored.

module ip_packet_rx #(
  parameter int MIN_FRAME_BYTES  = 36,
  parameter bit ACCEPT_BROADCAST = 1'b1
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic [31:0] ACCELERATOR_IP_ADDRESS,
  input  logic [47:0] ACCELERATOR_MAC_ADDRESS,
  input  logic [7:0]  MAC_DATA_IN,
  input  logic        MAC_DATA_VALID,
  output logic        MAC_DATA_READY,
  input  logic        MAC_DATA_LAST,
  input  logic        MAC_DATA_TUSER,
  output logic [47:0] SENDER_MAC_ADDRESS,
  output logic [31:0] SENDER_IP_ADDRESS,
  output logic [9:0]  SENDER_MESSAGE,
  output logic        MESSAGE_VALID,
  input  logic        MESSAGE_ACK,
  output logic [15:0] DROP_COUNT
);

  typedef enum logic {RECV, HOLD} state_t;

  localparam logic [5:0] MIN_LAST = 6'(MIN_FRAME_BYTES - 1);

  state_t      state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic        bad_q, bad_d;
  logic        own_mis_q, own_mis_d;   // dst MAC differs from own address
  logic        bc_mis_q, bc_mis_d;     // dst MAC differs from broadcast
  logic [47:0] smac_q, smac_d;         // shadow: src MAC of frame in flight
  logic [31:0] sip_q, sip_d;           // shadow: src IP
  logic [9:0]  smsg_q, smsg_d;         // shadow: message
  logic [47:0] mac_o_q, mac_o_d;
  logic [31:0] ip_o_q, ip_o_d;
  logic [9:0]  msg_o_q, msg_o_d;
  logic [15:0] drop_q, drop_d;

  logic        beat, err, frame_ok;
  logic        own_mis_now, bc_mis_now;
  logic [7:0]  own_mac_b, own_ip_b;
  logic [1:0]  ip_k;

`ifdef IP_RX_CHECKSUM_EN
  logic [16:0] cs_q, cs_d;             // raw sum; carry folded before next add
  logic [7:0]  cs_hi_q, cs_hi_d;       // high byte of the word being assembled
  logic [16:0] cs_sum;

  function automatic logic [15:0] fold16(input logic [16:0] x);
    return x[15:0] + 16'(x[16]);
  endfunction
`endif

  assign beat = MAC_DATA_VALID & MAC_DATA_READY;

  // Byte of own MAC / IP expected at the current index (first byte = MSBs).
  assign ip_k      = idx_q[1:0] + 2'd2;  // 30..33 -> 0..3
  assign own_mac_b = 8'(ACCELERATOR_MAC_ADDRESS >> {3'd5 - idx_q[2:0], 3'b000});
  assign own_ip_b  = 8'(ACCELERATOR_IP_ADDRESS >> {2'd3 - ip_k, 3'b000});

  // ---------------- FSM ----------------
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state_q <= RECV;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    MAC_DATA_READY = 1'b0;
    MESSAGE_VALID  = 1'b0;
    case (state_q)
      RECV: begin
        MAC_DATA_READY = 1'b1;
        if (beat && MAC_DATA_LAST && frame_ok) state_d = HOLD;
      end
      HOLD: begin
        MESSAGE_VALID = 1'b1;
        if (MESSAGE_ACK) state_d = RECV;
      end
      default: state_d = RECV;
    endcase
  end

  // ---------------- Parser / datapath ----------------
  always_comb begin
    idx_d     = idx_q;
    bad_d     = bad_q;
    own_mis_d = own_mis_q;
    bc_mis_d  = bc_mis_q;
    smac_d    = smac_q;
    sip_d     = sip_q;
    smsg_d    = smsg_q;
    mac_o_d   = mac_o_q;
    ip_o_d    = ip_o_q;
    msg_o_d   = msg_o_q;
    drop_d    = drop_q;
    err       = 1'b0;
    frame_ok  = 1'b0;
    own_mis_now = own_mis_q | (MAC_DATA_IN != own_mac_b);
    bc_mis_now  = bc_mis_q  | (MAC_DATA_IN != 8'hFF);
`ifdef IP_RX_CHECKSUM_EN
    cs_d    = cs_q;
    cs_hi_d = cs_hi_q;
    cs_sum  = {1'b0, fold16(cs_q)} + {9'd0, cs_hi_q, MAC_DATA_IN};
`endif

    if (beat) begin
      // Destination MAC: decided on its last byte, using this byte too.
      if (idx_q <= 6'd5) begin
        own_mis_d = own_mis_now;
        bc_mis_d  = bc_mis_now;
        if (idx_q == 6'd5 && own_mis_now && (!ACCEPT_BROADCAST || bc_mis_now))
          err = 1'b1;
      end
      if (idx_q >= 6'd6 && idx_q <= 6'd11) smac_d = {smac_q[39:0], MAC_DATA_IN};
      if (idx_q == 6'd12 && MAC_DATA_IN != 8'h08) err = 1'b1;
      if (idx_q == 6'd13 && MAC_DATA_IN != 8'h00) err = 1'b1;
      if (idx_q == 6'd14 && MAC_DATA_IN != 8'h45) err = 1'b1;
      if (idx_q >= 6'd26 && idx_q <= 6'd29) sip_d = {sip_q[23:0], MAC_DATA_IN};
      if (idx_q >= 6'd30 && idx_q <= 6'd33 && MAC_DATA_IN != own_ip_b) err = 1'b1;
      if (idx_q == 6'd34) smsg_d[9:8] = MAC_DATA_IN[1:0];
      if (idx_q == 6'd35) smsg_d[7:0] = MAC_DATA_IN;
`ifdef IP_RX_CHECKSUM_EN
      if (idx_q >= 6'd14 && idx_q <= 6'd33) begin
        if (!idx_q[0]) cs_hi_d = MAC_DATA_IN;
        else begin
          cs_d = cs_sum;
          // Whole header summed once byte 33 lands; valid header folds to all ones.
          if (idx_q == 6'd33 && fold16(cs_sum) != 16'hFFFF) err = 1'b1;
        end
      end
`endif

      if (MAC_DATA_LAST) begin
        frame_ok  = !(bad_q | err | (idx_q < MIN_LAST) | MAC_DATA_TUSER);
        idx_d     = 6'd0;
        bad_d     = 1'b0;
        own_mis_d = 1'b0;
        bc_mis_d  = 1'b0;
`ifdef IP_RX_CHECKSUM_EN
        cs_d    = 17'd0;
        cs_hi_d = 8'd0;
`endif
        if (frame_ok) begin
          // Take the _d shadows: the message byte may arrive on the LAST beat.
          mac_o_d = smac_d;
          ip_o_d  = sip_d;
          msg_o_d = smsg_d;
        end else if (drop_q != 16'hFFFF) begin
          drop_d = drop_q + 16'd1;
        end
      end else begin
        idx_d = (idx_q == 6'd63) ? idx_q : idx_q + 6'd1;
        bad_d = bad_q | err;
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      idx_q     <= '0;
      bad_q     <= 1'b0;
      own_mis_q <= 1'b0;
      bc_mis_q  <= 1'b0;
      smac_q    <= '0;
      sip_q     <= '0;
      smsg_q    <= '0;
      mac_o_q   <= '0;
      ip_o_q    <= '0;
      msg_o_q   <= '0;
      drop_q    <= '0;
    end else begin
      idx_q     <= idx_d;
      bad_q     <= bad_d;
      own_mis_q <= own_mis_d;
      bc_mis_q  <= bc_mis_d;
      smac_q    <= smac_d;
      sip_q     <= sip_d;
      smsg_q    <= smsg_d;
      mac_o_q   <= mac_o_d;
      ip_o_q    <= ip_o_d;
      msg_o_q   <= msg_o_d;
      drop_q    <= drop_d;
    end
  end

`ifdef IP_RX_CHECKSUM_EN
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      cs_q    <= '0;
      cs_hi_q <= '0;
    end else begin
      cs_q    <= cs_d;
      cs_hi_q <= cs_hi_d;
    end
  end
`endif

  assign SENDER_MAC_ADDRESS = mac_o_q;
  assign SENDER_IP_ADDRESS  = ip_o_q;
  assign SENDER_MESSAGE     = msg_o_q;
  assign DROP_COUNT         = drop_q;

endmodule

// File: tb/tb_ip_packet_rx.sv
// Directed bench for ip_packet_rx: frames built from a base header, expected
// messages queued when a good frame is driven and checked on MESSAGE_VALID.
module tb_ip_packet_rx;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [31:0] ACCELERATOR_IP_ADDRESS;
  logic [47:0] ACCELERATOR_MAC_ADDRESS;
  logic [7:0]  MAC_DATA_IN;
  logic        MAC_DATA_VALID, MAC_DATA_READY, MAC_DATA_LAST, MAC_DATA_TUSER;
  logic [47:0] SENDER_MAC_ADDRESS;
  logic [31:0] SENDER_IP_ADDRESS;
  logic [9:0]  SENDER_MESSAGE;
  logic        MESSAGE_VALID, MESSAGE_ACK;
  logic [15:0] DROP_COUNT;

  ip_packet_rx dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .ACCELERATOR_IP_ADDRESS(ACCELERATOR_IP_ADDRESS),
    .ACCELERATOR_MAC_ADDRESS(ACCELERATOR_MAC_ADDRESS),
    .MAC_DATA_IN(MAC_DATA_IN), .MAC_DATA_VALID(MAC_DATA_VALID),
    .MAC_DATA_READY(MAC_DATA_READY), .MAC_DATA_LAST(MAC_DATA_LAST),
    .MAC_DATA_TUSER(MAC_DATA_TUSER),
    .SENDER_MAC_ADDRESS(SENDER_MAC_ADDRESS), .SENDER_IP_ADDRESS(SENDER_IP_ADDRESS),
    .SENDER_MESSAGE(SENDER_MESSAGE), .MESSAGE_VALID(MESSAGE_VALID),
    .MESSAGE_ACK(MESSAGE_ACK), .DROP_COUNT(DROP_COUNT)
  );

  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic [47:0] mac;
    logic [31:0] ip;
    logic [9:0]  msg;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_drop = 16'd0;
  logic [7:0]  frame [0:59];
  int          gap   [0:59];

`ifdef IP_RX_CHECKSUM_EN
  localparam logic CS_ON = 1'b1;
`else
  localparam logic CS_ON = 1'b0;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic build_base();
    logic [7:0] b [0:35] = '{
      8'h32, 8'hda, 8'hbb, 8'had, 8'heb, 8'hd5,   // dst MAC
      8'h54, 8'hb0, 8'h0b, 8'hed, 8'hab, 8'hba,   // src MAC
      8'h08, 8'h00, 8'h45, 8'h00, 8'h00, 8'h2e,   // type, ver/IHL, TOS, length
      8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 8'h00,   // ID, flags, TTL, protocol
      8'h20, 8'hb3, 8'h01, 8'h02, 8'h03, 8'h04,   // checksum, src IP
      8'h0a, 8'h0b, 8'h0c, 8'h0d, 8'h01, 8'hff};  // dst IP, message
    for (int i = 0; i < 60; i++) begin
      frame[i] = (i < 36) ? b[i] : 8'h00;
      gap[i]   = 0;
    end
  endtask

  // Entered and left just after a falling edge.
  task automatic send_frame(input int nbytes, input logic tuser, input logic ok, input string tag);
    exp_t e;
    if (ok) begin
      e.mac = {frame[6], frame[7], frame[8], frame[9], frame[10], frame[11]};
      e.ip  = {frame[26], frame[27], frame[28], frame[29]};
      e.msg = {frame[34][1:0], frame[35]};
      sb.push_back(e);
    end else begin
      exp_drop = (exp_drop == 16'hFFFF) ? exp_drop : exp_drop + 16'd1;
    end
    for (int i = 0; i < nbytes; i++) begin
      for (int g = 0; g < gap[i]; g++) begin
        MAC_DATA_VALID = 1'b0;
        MAC_DATA_LAST  = 1'b0;
        @(negedge ACLK);
      end
      MAC_DATA_VALID = 1'b1;
      MAC_DATA_IN    = frame[i];
      MAC_DATA_LAST  = (i == nbytes - 1);
      MAC_DATA_TUSER = (i == nbytes - 1) ? tuser : 1'b0;
      @(negedge ACLK);
    end
    MAC_DATA_VALID = 1'b0;
    MAC_DATA_LAST  = 1'b0;
    MAC_DATA_TUSER = 1'b0;
    chk({tag, " valid"}, 64'(MESSAGE_VALID), 64'(ok));
    chk({tag, " drop"}, 64'(DROP_COUNT), 64'(exp_drop));
    if (MESSAGE_VALID) begin
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({tag, " mac"}, 64'(SENDER_MAC_ADDRESS), 64'(e.mac));
        chk({tag, " ip"},  64'(SENDER_IP_ADDRESS),  64'(e.ip));
        chk({tag, " msg"}, 64'(SENDER_MESSAGE),     64'(e.msg));
      end else begin
        chk({tag, " unexpected msg"}, 64'(1), 64'(0));
      end
      chk({tag, " ready hold"}, 64'(MAC_DATA_READY), 64'(0));
      repeat (2) @(negedge ACLK);
      chk({tag, " valid held"}, 64'(MESSAGE_VALID), 64'(1));
      MESSAGE_ACK = 1'b1;
      @(negedge ACLK);
      MESSAGE_ACK = 1'b0;
      chk({tag, " valid after ack"}, 64'(MESSAGE_VALID), 64'(0));
      chk({tag, " ready after ack"}, 64'(MAC_DATA_READY), 64'(1));
    end else begin
      if (sb.size() > 0) void'(sb.pop_front());
      chk({tag, " ready idle"}, 64'(MAC_DATA_READY), 64'(1));
    end
  endtask

  initial begin
    ARESET = 1'b1;
    MESSAGE_ACK = 1'b0;
    MAC_DATA_IN = 8'h00;
    MAC_DATA_VALID = 1'b0;
    MAC_DATA_LAST = 1'b0;
    MAC_DATA_TUSER = 1'b0;
    ACCELERATOR_MAC_ADDRESS = 48'h32dabbadebd5;
    ACCELERATOR_IP_ADDRESS  = 32'h0a0b0c0d;
    #12;
    chk("rst ready", 64'(MAC_DATA_READY), 64'(1));
    chk("rst valid", 64'(MESSAGE_VALID), 64'(0));
    chk("rst mac",   64'(SENDER_MAC_ADDRESS), 64'(0));
    chk("rst ip",    64'(SENDER_IP_ADDRESS), 64'(0));
    chk("rst msg",   64'(SENDER_MESSAGE), 64'(0));
    chk("rst drop",  64'(DROP_COUNT), 64'(0));
    @(negedge ACLK);
    ARESET = 1'b0;
    @(negedge ACLK);

    // 1: base frame, with explicit constant checks of the extracted fields
    build_base();
    sb.push_back('{mac: 48'h54b00bedabba, ip: 32'h01020304, msg: 10'h1ff});
    void'(sb.pop_back());
    send_frame(60, 1'b0, 1'b1, "t1 base");
    chk("t1 msg const", 64'(SENDER_MESSAGE), 64'h1ff);
    chk("t1 ip const",  64'(SENDER_IP_ADDRESS), 64'h01020304);
    chk("t1 mac const", 64'(SENDER_MAC_ADDRESS), 64'h54b00bedabba);

    // 2: corrupted checksum byte
    build_base();
    frame[25] = 8'hb4;
    frame[35] = 8'h3c;
    send_frame(60, 1'b0, !CS_ON, "t2 cksum");

    // 3: wrong dst IP; broadcast dst MAC
    build_base();
    frame[33] = 8'h0e;
    send_frame(60, 1'b0, 1'b0, "t3 dst ip");
    build_base();
    for (int i = 0; i < 6; i++) frame[i] = 8'hff;
    frame[34] = 8'h02;
    frame[35] = 8'h5a;
    send_frame(60, 1'b0, 1'b1, "t3 bcast");

    // 3b: unicast dst MAC that is neither own nor broadcast
    build_base();
    frame[2] = 8'hbc;
    send_frame(60, 1'b0, 1'b0, "t3 dst mac");

    // 4: VALID gaps mid-frame; TUSER on LAST
    build_base();
    gap[4] = 1; gap[5] = 2; gap[6] = 3; gap[7] = 4; gap[20] = 5; gap[33] = 6;
    send_frame(60, 1'b0, 1'b1, "t4 gaps");
    build_base();
    send_frame(60, 1'b1, 1'b0, "t4 tuser");

    // 5: runt (LAST at byte 30), then a good minimum-length frame
    build_base();
    send_frame(31, 1'b0, 1'b0, "t5 runt");
    build_base();
    frame[11] = 8'h77;
    frame[35] = 8'h81;
    send_frame(36, 1'b0, 1'b1, "t5 min frame");

    // ACK while idle has no effect
    MESSAGE_ACK = 1'b1;
    @(negedge ACLK);
    MESSAGE_ACK = 1'b0;
    chk("idle ack valid", 64'(MESSAGE_VALID), 64'(0));
    chk("idle ack ready", 64'(MAC_DATA_READY), 64'(1));

    // 6: reset at byte 20
    build_base();
    for (int i = 0; i < 20; i++) begin
      MAC_DATA_VALID = 1'b1;
      MAC_DATA_IN    = frame[i];
      @(negedge ACLK);
    end
    MAC_DATA_IN = frame[20];
    #2 ARESET = 1'b1;
    MAC_DATA_VALID = 1'b0;
    #1;
    chk("t6 rst ready", 64'(MAC_DATA_READY), 64'(1));
    chk("t6 rst valid", 64'(MESSAGE_VALID), 64'(0));
    chk("t6 rst mac",   64'(SENDER_MAC_ADDRESS), 64'(0));
    chk("t6 rst ip",    64'(SENDER_IP_ADDRESS), 64'(0));
    chk("t6 rst msg",   64'(SENDER_MESSAGE), 64'(0));
    chk("t6 rst drop",  64'(DROP_COUNT), 64'(0));
    @(negedge ACLK);
    ARESET = 1'b0;
    exp_drop = 16'd0;
    @(negedge ACLK);
    build_base();
    send_frame(60, 1'b0, 1'b1, "t6 fresh");

    // 6b: drop counter saturation with back-to-back one-byte runts
    MAC_DATA_VALID = 1'b1;
    MAC_DATA_LAST  = 1'b1;
    MAC_DATA_IN    = 8'h00;
    repeat (65534) @(negedge ACLK);
    chk("sat drop fffe", 64'(DROP_COUNT), 64'hfffe);
    repeat (3) @(negedge ACLK);
    chk("sat drop ffff", 64'(DROP_COUNT), 64'hffff);
    MAC_DATA_VALID = 1'b0;
    MAC_DATA_LAST  = 1'b0;
    @(negedge ACLK);
    exp_drop = 16'hffff;
    build_base();
    frame[12] = 8'h86;
    send_frame(60, 1'b0, 1'b0, "sat ethertype");
    build_base();
    send_frame(60, 1'b0, 1'b1, "final good");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ip_packet_rx.md
Name: ip_packet_rx

Overview:
- Receive-side counterpart of ip_packet_tx.
- Accepts a byte-serial Ethernet II + IPv4 frame from the MAC RX stream and validates the Ethernet and IPv4 headers.
- Extracts the 10-bit accelerator message plus the sender's MAC and IP addresses.
- Holds the result for the accelerator until acknowledged; back-pressures the MAC meanwhile.

Parameters:
MIN_FRAME_BYTES, 36, frames whose LAST beat arrives at byte index < MIN_FRAME_BYTES-1 are rejected (36 = headers + 2 message bytes)
ACCEPT_BROADCAST, 1, 1: destination MAC FF:FF:FF:FF:FF:FF also accepted

Ports:
ACLK  in  1  clock, rising edge
ARESET  in  1  reset, asynchronous, active-high
ACCELERATOR_IP_ADDRESS  in  32  own IPv4 address, bit 0 = MSB
ACCELERATOR_MAC_ADDRESS  in  48  own MAC address, bit 0 = MSB
MAC_DATA_IN  in  8  RX byte
MAC_DATA_VALID  in  1  byte valid
MAC_DATA_READY  out  1  block can accept a byte
MAC_DATA_LAST  in  1  final byte of frame
MAC_DATA_TUSER  in  1  MAC frame error, sampled with LAST
SENDER_MAC_ADDRESS  out  48  source MAC of the accepted frame
SENDER_IP_ADDRESS  out  32  source IP of the accepted frame
SENDER_MESSAGE  out  10  message of the accepted frame
MESSAGE_VALID  out  1  SENDER_* outputs valid
MESSAGE_ACK  in  1  accelerator consumed message
DROP_COUNT  out  16  rejected-frame count, saturates at 0xFFFF

Behaviour:
- Beat = MAC_DATA_VALID & MAC_DATA_READY on a rising edge. A 6-bit byte index starts at 0, increments per beat, saturates at 63, and clears after a LAST beat.
- Frame byte map: 0-5 dst MAC; 6-11 src MAC; 12-13 ethertype; 14 ver/IHL; 15 TOS; 16-17 length; 18-19 ID; 20-21 flags/frag; 22 TTL; 23 protocol; 24-25 checksum; 26-29 src IP; 30-33 dst IP; 34 low 2 bits = message[0:1]; 35 = message[2:9]; bytes ≥36 are padding/FCS and ignored.
- Sticky per-frame bad flag is set by any of:
  - dst MAC ≠ ACCELERATOR_MAC_ADDRESS (and not broadcast when ACCEPT_BROADCAST=1)
  - ethertype ≠ 0x0800
  - byte 14 ≠ 0x45
  - dst IP ≠ ACCELERATOR_IP_ADDRESS
  - checksum failure (see Optional Feature)
  - LAST at index < MIN_FRAME_BYTES-1
  - TUSER=1 on the LAST beat
- TOS, length, ID, flags, TTL and protocol are not checked.
- Address fields compare against the port values as sampled during the frame.
- State RECV (reset state):
  - READY=1.
  - Captures src MAC, src IP and message bytes into shadow registers.
  - On the LAST beat with bad clear: go to HOLD; SENDER_* load; MESSAGE_VALID=1 from the next cycle.
  - On the LAST beat with bad set: stay in RECV; DROP_COUNT+1 (saturating); SENDER_* unchanged.
  - Bad flag and checksum accumulator clear after every LAST beat.
- State HOLD:
  - READY=0; MESSAGE_VALID=1; SENDER_* stable.
  - MESSAGE_ACK=1 sampled → next cycle MESSAGE_VALID=0, READY=1, state RECV.
  - ACK is ignored in RECV.
  - No byte is accepted in the ACK cycle.
- Latency: MESSAGE_VALID rises 1 cycle after the accepted LAST beat. Minimum gap between consecutive accepted frames' LAST beats is 1 cycle after ACK.
- VALID gaps mid-frame are allowed; index and state hold.
- Reset values: MAC_DATA_READY=1, MESSAGE_VALID=0, SENDER_MAC_ADDRESS=0, SENDER_IP_ADDRESS=0, SENDER_MESSAGE=0, DROP_COUNT=0; index 0, bad flag 0, state RECV.
- ARESET mid-frame: partial frame is discarded without counting. The MAC is responsible for not resuming a frame across reset; any tail presented afterwards is parsed as a new frame and is rejected by the field checks.

Optional Feature:
- IP_RX_CHECKSUM_EN defined:
  - Bytes 14-33 are accumulated as ten big-endian 16-bit words into a 17-bit register with end-around carry folded on every word.
  - At the LAST beat (or after byte 33, whichever the frame reaches), a folded sum ≠ 0xFFFF sets the bad flag.
  - Frames ending before byte 33 are already rejected by the length check.
- Not defined: checksum bytes are ignored; no accumulator is instantiated.

Test Plan:
1. Valid 60-byte frame, all VALID=1, with:
   - ACCELERATOR_MAC=32dabbadebd5, ACCELERATOR_IP=0a0b0c0d
   - src MAC 54b00bedabba, src IP 01020304, length 0x002E, TTL 0x80, checksum 0x20B3, bytes 34-35 = 01 FF
   → MESSAGE_VALID=1 one cycle after LAST; SENDER_MESSAGE=0x1FF; SENDER_IP=01020304; SENDER_MAC=54b00bedabba; READY=0 until ACK pulse, then READY=1 next cycle.
2. Same frame with byte 25 = 0xB4 → with IP_RX_CHECKSUM_EN: no MESSAGE_VALID, DROP_COUNT=1; without: accepted.
3. dst IP 0a0b0c0e → dropped, DROP_COUNT+1. Dst MAC FFFFFFFFFFFF with ACCEPT_BROADCAST=1 → accepted.
4. Frame 1 with VALID low on bytes 4-7, 20, 33 for 1-6 cycles each → identical capture. Same frame with TUSER=1 on LAST → dropped.
5. LAST at byte 30 → dropped, DROP_COUNT+1; the next valid frame is accepted normally (index restarted at 0).
6. ARESET pulse at byte 20 → all outputs return to reset values immediately, DROP_COUNT=0. A fresh valid frame is then accepted. DROP_COUNT saturates at 0xFFFF after 65536+ bad frames (forced via 65537 runt frames).
